// File: rtl/mac_array_ctrl_if.sv
// Bundle between the MAC array sequencer and its environment: start/status, operand buffer
// read port, MAC array drive/feedback and the result handshake.
interface mac_array_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned K_W    = 8
);
  logic                     start;
  logic [K_W-1:0]           k_len;
  logic                     busy;
  logic                     done;

  logic                     rd_en;
  logic [K_W-1:0]           rd_addr;
  logic [2*DATA_W-1:0]      rd_a_data;
  logic [2*DATA_W-1:0]      rd_b_data;

  logic                     mac_en;
  logic                     mac_clear;
  logic signed [DATA_W-1:0] mac_a   [2][2];
  logic signed [DATA_W-1:0] mac_b   [2][2];
  logic signed [ACC_W-1:0]  mac_acc [2][2];

  logic                     res_valid;
  logic                     res_ready;
  logic [4*ACC_W-1:0]       res_data;

  modport master (
    input  start, k_len, rd_a_data, rd_b_data, mac_acc, res_ready,
    output busy, done, rd_en, rd_addr, mac_en, mac_clear, mac_a, mac_b, res_valid, res_data
  );

  modport slave (
    output start, k_len, rd_a_data, rd_b_data, mac_acc, res_ready,
    input  busy, done, rd_en, rd_addr, mac_en, mac_clear, mac_a, mac_b, res_valid, res_data
  );
endinterface

// File: rtl/mac_array_ctrl.sv
// Sequencer for a 2x2 signed MAC array: streams K outer-product terms from the operand buffers
// into the array, then presents the four accumulators behind a valid/ready handshake.
module mac_array_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned K_W    = 8
) (
  input logic              clk,
  input logic              rst_n,
  mac_array_ctrl_if.master ctrl_io
);

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StCapture, StOut} state_e;

  state_e             state_q;
  logic [K_W-1:0]     k_len_q;
  logic [K_W-1:0]     rd_addr_q;
  logic               busy_q;
  logic               done_q;
  logic               rd_en_q;
  logic               mac_en_q;
  logic               mac_clear_q;
  logic               res_valid_q;
  logic [4*ACC_W-1:0] res_data_q;
  logic [4*ACC_W-1:0] acc_packed;

  // Result word order is C00 in the LSBs, then C01, C10, C11.
  always_comb begin
    acc_packed = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        acc_packed[(2*i+j)*ACC_W +: ACC_W] = ctrl_io.mac_acc[i][j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      k_len_q     <= '0;
      rd_addr_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_clear_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      done_q      <= 1'b0;
      mac_clear_q <= 1'b0;
      // Read data lands one cycle after the strobe, so the array enable trails it by one.
      mac_en_q    <= rd_en_q;
      case (state_q)
        StIdle: begin
          if (ctrl_io.start && (ctrl_io.k_len != '0)) begin
            k_len_q     <= ctrl_io.k_len;
            rd_addr_q   <= '0;
            rd_en_q     <= 1'b1;
            mac_clear_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= StFetch;
          end
        end
        StFetch: begin
          if (rd_addr_q == k_len_q - K_W'(1)) begin
            rd_en_q <= 1'b0;
            state_q <= StWait;
          end else begin
            rd_addr_q <= rd_addr_q + K_W'(1);
          end
        end
        StWait: begin
          state_q <= StCapture;
        end
        StCapture: begin
          res_data_q  <= acc_packed;
          res_valid_q <= 1'b1;
          state_q     <= StOut;
        end
        StOut: begin
          if (ctrl_io.res_ready) begin
            res_valid_q <= 1'b0;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Outer-product broadcast: row operand comes from A lane i, column operand from B lane j.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        ctrl_io.mac_a[i][j] = mac_en_q ? ctrl_io.rd_a_data[i*DATA_W +: DATA_W] : '0;
        ctrl_io.mac_b[i][j] = mac_en_q ? ctrl_io.rd_b_data[j*DATA_W +: DATA_W] : '0;
      end
    end
  end

  assign ctrl_io.busy      = busy_q;
  assign ctrl_io.done      = done_q;
  assign ctrl_io.rd_en     = rd_en_q;
  assign ctrl_io.rd_addr   = rd_addr_q;
  assign ctrl_io.mac_en    = mac_en_q;
  assign ctrl_io.mac_clear = mac_clear_q;
  assign ctrl_io.res_valid = res_valid_q;
  assign ctrl_io.res_data  = res_data_q;

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Bench for mac_array_ctrl: behavioural operand buffers and MAC array around the DUT, with
// results checked against a direct matrix-product model and the cycle timeline.
module tb_mac_array_ctrl;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 32;
  localparam int unsigned KW = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_done  = 0;

  logic signed [DW-1:0] a_mem [2][256];
  logic signed [DW-1:0] b_mem [256][2];

  mac_array_ctrl_if #(.DATA_W(DW), .ACC_W(AW), .K_W(KW)) bus ();

  mac_array_ctrl #(.DATA_W(DW), .ACC_W(AW), .K_W(KW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ctrl_io (bus)
  );

  always #5 clk = ~clk;

  // Operand buffers: one-cycle read latency.
  always_ff @(posedge clk) begin
    if (bus.rd_en) begin
      bus.rd_a_data <= {a_mem[1][bus.rd_addr], a_mem[0][bus.rd_addr]};
      bus.rd_b_data <= {b_mem[bus.rd_addr][1], b_mem[bus.rd_addr][0]};
    end
  end

  // MAC array: clear has priority over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        if (!rst_n) bus.mac_acc[i][j] <= '0;
        else if (bus.mac_clear) bus.mac_acc[i][j] <= '0;
        else if (bus.mac_en)
          bus.mac_acc[i][j] <= bus.mac_acc[i][j] + int'(bus.mac_a[i][j]) * int'(bus.mac_b[i][j]);
      end
    end
  end

  always @(negedge clk) begin
    if (bus.done === 1'b1) n_done <= n_done + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model(input int klen);
    int acc [2][2];
    for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) acc[i][j] = 0;
    for (int k = 0; k < klen; k++)
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++)
          acc[i][j] += int'(a_mem[i][k]) * int'(b_mem[k][j]);
    return {acc[1][1], acc[1][0], acc[0][1], acc[0][0]};
  endfunction

  task automatic load_t1();
    a_mem[0][0] = 8'sd1; a_mem[0][1] = 8'sd2; a_mem[1][0] = 8'sd3; a_mem[1][1] = 8'sd4;
    b_mem[0][0] = 8'sd5; b_mem[0][1] = 8'sd6; b_mem[1][0] = 8'sd7; b_mem[1][1] = 8'sd8;
  endtask

  task automatic fill(input int klen, input bit rnd, input logic signed [DW-1:0] val);
    for (int k = 0; k < klen; k++) begin
      for (int i = 0; i < 2; i++) begin
        a_mem[i][k] = rnd ? DW'($urandom) : val;
        b_mem[k][i] = rnd ? DW'($urandom) : val;
      end
    end
  endtask

  task automatic idle_check(input string tag, input int ncyc);
    bit ok = 1'b1;
    for (int n = 0; n < ncyc; n++) begin
      step();
      if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0 || bus.done !== 1'b0) ok = 1'b0;
    end
    check(tag, ok, 1'b1);
  endtask

  // Starts a job in the current (idle) cycle and returns in the cycle where done is high.
  task automatic run_job(input int klen, input int hold, input bit poke, input string tag,
                         output logic [127:0] res);
    logic [127:0] exp_res;
    bit seq_ok = 1'b1, bc_ok = 1'b1, out_ok = 1'b1;
    int n_rd = 0, n_en = 0;
    exp_res = model(klen);
    bus.res_ready = (hold == 0);
    bus.k_len = KW'(klen);
    bus.start = 1'b1;
    check({tag, "/busy_before"}, bus.busy, 1'b0);
    step();
    bus.start = poke;
    bus.k_len = KW'($urandom);
    for (int c = 1; c <= klen + 2; c++) begin
      if (bus.rd_en !== (c <= klen)) seq_ok = 1'b0;
      if (bus.rd_en === 1'b1 && bus.rd_addr !== KW'(c - 1)) seq_ok = 1'b0;
      if (bus.mac_en !== (c >= 2 && c <= klen + 1)) seq_ok = 1'b0;
      if (bus.mac_clear !== (c == 1)) seq_ok = 1'b0;
      if (bus.res_valid !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b1) seq_ok = 1'b0;
      if (bus.mac_en === 1'b1 && c >= 2) begin
        for (int i = 0; i < 2; i++)
          for (int j = 0; j < 2; j++)
            if (bus.mac_a[i][j] !== a_mem[i][c-2] || bus.mac_b[i][j] !== b_mem[c-2][j])
              bc_ok = 1'b0;
      end
      if (bus.rd_en === 1'b1) n_rd++;
      if (bus.mac_en === 1'b1) n_en++;
      step();
      bus.start = 1'b0;
    end
    check({tag, "/timeline"}, seq_ok, 1'b1);
    check({tag, "/broadcast"}, bc_ok, 1'b1);
    check({tag, "/rd_en_cycles"}, n_rd, klen);
    check({tag, "/mac_en_cycles"}, n_en, klen);
    check({tag, "/res_valid"}, bus.res_valid, 1'b1);
    check({tag, "/res_data"}, bus.res_data, exp_res);
    res = bus.res_data;
    bus.start = poke;
    for (int h = 0; h < hold; h++) begin
      if (bus.res_valid !== 1'b1 || bus.res_data !== res || bus.done !== 1'b0 ||
          bus.busy !== 1'b1) out_ok = 1'b0;
      if (h == hold - 1) bus.res_ready = 1'b1;
      step();
      bus.start = 1'b0;
    end
    if (hold == 0) step();
    bus.start = 1'b0;
    if (hold > 0) check({tag, "/held"}, out_ok, 1'b1);
    check({tag, "/done"}, bus.done, 1'b1);
    check({tag, "/busy_after"}, bus.busy, 1'b0);
    check({tag, "/valid_after"}, bus.res_valid, 1'b0);
  endtask

  initial begin
    logic [127:0] res;
    int n0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.k_len = '0;
    bus.res_ready = 1'b1;
    repeat (2) step();
    check("rst/busy", bus.busy, 1'b0);
    check("rst/done", bus.done, 1'b0);
    check("rst/rd_en", bus.rd_en, 1'b0);
    check("rst/rd_addr", bus.rd_addr, 0);
    check("rst/mac_en", bus.mac_en, 1'b0);
    check("rst/mac_clear", bus.mac_clear, 1'b0);
    check("rst/res_valid", bus.res_valid, 1'b0);
    check("rst/res_data", bus.res_data, 0);
    check("rst/mac_a", bus.mac_a[1][0], 0);
    check("rst/mac_b", bus.mac_b[0][1], 0);
    rst_n = 1'b1;
    step();

    // Basic 2x2x2 product.
    load_t1();
    n0 = n_done;
    run_job(2, 0, 1'b0, "t1", res);
    check("t1/const", res, {32'd50, 32'd43, 32'd22, 32'd19});
    idle_check("t1/idle", 2);
    check("t1/one_done", n_done, n0 + 1);

    // Extreme operands, then a back-to-back job to prove the clear.
    a_mem[0][0] = -8'sd128; a_mem[1][0] = 8'sd127;
    b_mem[0][0] = -8'sd128; b_mem[0][1] = 8'sd2;
    run_job(1, 0, 1'b0, "t2", res);
    check("t2/const", res, {32'h0000_00FE, 32'hFFFF_C080, 32'hFFFF_FF00, 32'h0000_4000});
    load_t1();
    run_job(2, 0, 1'b0, "t2b", res);
    check("t2b/const", res, {32'd50, 32'd43, 32'd22, 32'd19});
    idle_check("t2b/idle", 1);

    // Backpressure: res_ready low for five OUT cycles.
    fill(2, 1'b1, 8'sd0);
    n0 = n_done;
    run_job(2, 6, 1'b0, "bp", res);
    idle_check("bp/idle", 2);
    check("bp/one_done", n_done, n0 + 1);

    // start pulsed in FETCH and OUT, then start with k_len=0.
    fill(3, 1'b1, 8'sd0);
    n0 = n_done;
    run_job(3, 2, 1'b1, "poke", res);
    idle_check("poke/idle", 3);
    check("poke/one_done", n_done, n0 + 1);
    n0 = n_done;
    bus.k_len = '0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("klen0/busy", bus.busy, 1'b0);
    check("klen0/rd_en", bus.rd_en, 1'b0);
    idle_check("klen0/idle", 3);
    check("klen0/no_done", n_done, n0);

    // Asynchronous reset in the middle of a long fetch.
    fill(200, 1'b1, 8'sd0);
    n0 = n_done;
    bus.k_len = KW'(200);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (50) step();
    check("rstmid/addr50", bus.rd_addr, 50);
    check("rstmid/busy_pre", bus.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid/busy", bus.busy, 1'b0);
    check("rstmid/rd_en", bus.rd_en, 1'b0);
    check("rstmid/mac_en", bus.mac_en, 1'b0);
    check("rstmid/res_valid", bus.res_valid, 1'b0);
    check("rstmid/res_data", bus.res_data, 0);
    check("rstmid/mac_a", bus.mac_a[1][1], 0);
    step();
    rst_n = 1'b1;
    idle_check("rstmid/idle", 3);
    check("rstmid/no_done", n_done, n0);
    load_t1();
    run_job(2, 0, 1'b0, "rstmid/job", res);
    check("rstmid/const", res, {32'd50, 32'd43, 32'd22, 32'd19});
    idle_check("rstmid/idle2", 1);

    // Longest job, all operands 127.
    fill(255, 1'b0, 8'sd127);
    run_job(255, 0, 1'b0, "k255", res);
    check("k255/const", res, {4{32'd4112895}});
    idle_check("k255/idle", 1);

    // Random jobs with random backpressure and gaps.
    for (int r = 0; r < 8; r++) begin
      int kl, hd;
      kl = int'($urandom_range(1, 16));
      hd = int'($urandom_range(0, 3));
      fill(kl, 1'b1, 8'sd0);
      run_job(kl, hd, r[0], $sformatf("rnd%0d", r), res);
      if (r[1]) idle_check($sformatf("rnd%0d/idle", r), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
